// File: rtl/carrd_issue_queue_pkg.sv
// ----------------------------------------------------------------------------
// carrd_issue_queue_pkg
// Shared types and constants for the CARRD issue queue: FSM state encoding,
// the RISC-V vector opcode fields that identify a vconfig instruction (vsetvl,
// vsetvli, vsetivli), and the packed entry type the FIFO stores.
// No ports.
// ----------------------------------------------------------------------------
package carrd_issue_queue_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT
   } state_e;

   localparam logic [6:0] OPC_VECTOR   = 7'b1010111;
   localparam logic [2:0] FUNCT3_OPCFG = 3'b111;

   // One FIFO entry: the instruction word and the scalar rs1 value that the
   // base processor captured alongside it.
   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] xreg;
   } issue_entry_t;

   localparam int ENTRY_W = $bits(issue_entry_t);

   // vconfig instructions complete on issue and never see a done pulse.
   function automatic logic isVconfig(input logic [31:0] instr);
      return (instr[6:0] == OPC_VECTOR) && (instr[14:12] == FUNCT3_OPCFG);
   endfunction

endpackage

// File: rtl/carrd_issue_queue_if.sv
// ----------------------------------------------------------------------------
// carrd_issue_queue_if
// Bundles the base-processor push side, the coprocessor issue side, the unit
// completion pulses and the status outputs of carrd_issue_queue.
//   master : the environment (base processor + coprocessor) side
//   slave  : the issue queue side
// Parameter DEPTH sizes q_count ($clog2(DEPTH)+1 bits).
// ----------------------------------------------------------------------------
interface carrd_issue_queue_if #(
   parameter int DEPTH = 4
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic          base_valid;
   logic [31:0]   base_instr;
   logic [31:0]   base_xreg;
   logic          base_ready;
   logic          flush;
   logic          op_valid;
   logic [31:0]   op_instr;
   logic [31:0]   op_xreg;
   logic          done_vlanes;
   logic          done_vred;
   logic          done_vsldu;
   logic          busy;
   logic [CW-1:0] q_count;
   logic          err_timeout;

   modport master (
      output base_valid, base_instr, base_xreg, flush,
             done_vlanes, done_vred, done_vsldu,
      input  base_ready, op_valid, op_instr, op_xreg,
             busy, q_count, err_timeout
   );

   modport slave (
      input  base_valid, base_instr, base_xreg, flush,
             done_vlanes, done_vred, done_vsldu,
      output base_ready, op_valid, op_instr, op_xreg,
             busy, q_count, err_timeout
   );

endinterface

// File: rtl/carrd_instr_fifo.sv
// ----------------------------------------------------------------------------
// carrd_instr_fifo
// Power-of-two synchronous FIFO holding issue entries.
//   clk, nrst      : clock, asynchronous active-low reset
//   i_push, i_data : write request and data (ignored while full or flushing)
//   i_pop          : read request (ignored while empty or flushing)
//   i_flush        : synchronous clear of both pointers
//   o_data         : current head entry (valid when !o_empty)
//   o_full, o_empty, o_count : occupancy status
// A push while full is refused even if a pop happens in the same cycle.
// ----------------------------------------------------------------------------
module carrd_instr_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 64
) (
   input  logic                     clk,
   input  logic                     nrst,
   input  logic                     i_push,
   input  logic                     i_pop,
   input  logic                     i_flush,
   input  logic [WIDTH-1:0]         i_data,
   output logic [WIDTH-1:0]         o_data,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic [AW:0]      r_wrPtr;
   logic [AW:0]      r_rdPtr;
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic             w_doPush;
   logic             w_doPop;

   // Pointers carry one extra wrap bit so full and empty are distinguishable
   // when the index bits match.
   assign o_full   = (r_wrPtr[AW] != r_rdPtr[AW]) && (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
   assign o_empty  = (r_wrPtr == r_rdPtr);
   assign o_count  = r_wrPtr - r_rdPtr;
   assign o_data   = r_mem[r_rdPtr[AW-1:0]];
   assign w_doPush = i_push && !o_full && !i_flush;
   assign w_doPop  = i_pop && !o_empty && !i_flush;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
      end else if (i_flush) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
      end else begin
         if (w_doPush) r_wrPtr <= r_wrPtr + PTR_ONE;
         if (w_doPop)  r_rdPtr <= r_rdPtr + PTR_ONE;
      end
   end

   // Storage needs no reset: an entry is only read after it has been written.
   always_ff @(posedge clk) begin
      if (w_doPush) r_mem[r_wrPtr[AW-1:0]] <= i_data;
   end

endmodule

// File: rtl/carrd_issue_queue.sv
// ----------------------------------------------------------------------------
// carrd_issue_queue
// Upstream issue stage for the CARRD vector coprocessor. Buffers
// {instruction, scalar operand} pairs from the base processor and issues them
// one at a time, holding each non-vconfig op until a unit reports done.
//   clk, nrst : clock, asynchronous active-low reset
//   bus       : carrd_issue_queue_if.slave (push side, issue side, done
//               pulses, busy / q_count / err_timeout status)
// Parameters: DEPTH (power of two, 2..16), TIMEOUT_CYCLES (watchdog limit).
// Optional feature macro: CARRD_ISSUE_TIMEOUT_EN enables the WAIT watchdog;
// without it err_timeout is tied low and WAIT waits indefinitely.
// ----------------------------------------------------------------------------
module carrd_issue_queue
   import carrd_issue_queue_pkg::*;
#(
   parameter int DEPTH          = 4,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                   clk,
   input  logic                   nrst,
   carrd_issue_queue_if.slave     bus
);
   logic                   w_full;
   logic                   w_empty;
   logic                   w_pop;
   logic                   w_doneAny;
   logic                   w_errTimeout;
   logic [$clog2(DEPTH):0] w_count;
   issue_entry_t           w_head;

   state_e                 r_state;
   state_e                 w_nextState;
   logic                   r_opValid;
   logic [31:0]            r_opInstr;
   logic [31:0]            r_opXreg;

   carrd_instr_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (ENTRY_W)
   ) u_fifo (
      .clk     (clk),
      .nrst    (nrst),
      .i_push  (bus.base_valid),
      .i_pop   (w_pop),
      .i_flush (bus.flush),
      .i_data  ({bus.base_instr, bus.base_xreg}),
      .o_data  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   assign w_doneAny = bus.done_vlanes | bus.done_vred | bus.done_vsldu;

   // The limit must fit the widest watchdog counter; this guard keeps the
   // parameter referenced even when the watchdog is compiled out.
   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_badTimeoutLimit
   end

`ifdef CARRD_ISSUE_TIMEOUT_EN
   localparam int WD_W = (TIMEOUT_CYCLES > 255) ? 16 : 8;
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
   localparam logic [WD_W-1:0] WD_ONE  = {{(WD_W-1){1'b0}}, 1'b1};

   logic [WD_W-1:0] r_wdCount;
   logic            r_errTimeout;
   logic            w_timeoutHit;
`endif

   // Next-state and pop decision. flush wins over everything; done pulses
   // seen while IDLE are simply not looked at.
   always_comb begin
      w_nextState = r_state;
      w_pop       = 1'b0;
`ifdef CARRD_ISSUE_TIMEOUT_EN
      w_timeoutHit = 1'b0;
`endif
      if (bus.flush) begin
         w_nextState = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (!w_empty) begin
                  w_pop       = 1'b1;
                  w_nextState = S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (isVconfig(r_opInstr) || w_doneAny) w_nextState = S_IDLE;
               else                                   w_nextState = S_WAIT;
            end
            S_WAIT: begin
               if (w_doneAny) begin
                  w_nextState = S_IDLE;
               end
`ifdef CARRD_ISSUE_TIMEOUT_EN
               else if (r_wdCount == WD_LAST) begin
                  w_nextState  = S_IDLE;
                  w_timeoutHit = 1'b1;
               end
`endif
            end
            default: w_nextState = S_IDLE;
         endcase
      end
   end

   // State and issue registers. op_valid is exactly the pop of the previous
   // cycle, so it is a one-cycle pulse; instr/xreg hold until the next pop.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_state   <= S_IDLE;
         r_opValid <= 1'b0;
         r_opInstr <= '0;
         r_opXreg  <= '0;
      end else begin
         r_state   <= w_nextState;
         r_opValid <= w_pop;
         if (w_pop) begin
            r_opInstr <= w_head.instr;
            r_opXreg  <= w_head.xreg;
         end
      end
   end

`ifdef CARRD_ISSUE_TIMEOUT_EN
   // Watchdog: the counter sits at zero outside WAIT, so it is cleared on
   // entry and counts WAIT cycles. The error flag survives flush.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_wdCount    <= '0;
         r_errTimeout <= 1'b0;
      end else begin
         if (r_state != S_WAIT) r_wdCount <= '0;
         else                   r_wdCount <= r_wdCount + WD_ONE;
         if (w_timeoutHit) r_errTimeout <= 1'b1;
      end
   end

   assign w_errTimeout = r_errTimeout;
`else
   assign w_errTimeout = 1'b0;
`endif

   assign bus.base_ready  = !w_full;
   assign bus.op_valid    = r_opValid;
   assign bus.op_instr    = r_opInstr;
   assign bus.op_xreg     = r_opXreg;
   assign bus.busy        = (r_state != S_IDLE) || !w_empty;
   assign bus.q_count     = w_count;
   assign bus.err_timeout = w_errTimeout;

endmodule

// File: tb/tb_carrd_issue_queue.sv
// ----------------------------------------------------------------------------
// tb_carrd_issue_queue
// Self-checking bench for carrd_issue_queue: a table of directed vectors,
// hand-written async-reset and watchdog sequences, and a randomized run
// against a queue-based reference model.
// ----------------------------------------------------------------------------
module tb_carrd_issue_queue;

   localparam int DEPTH   = 4;
   localparam int TIMEOUT = 10;

   localparam logic [31:0] VADD = 32'h0220_8057;   // vadd.vv, funct3 000
   localparam logic [31:0] VSET = 32'h00D0_7057;   // vsetvli, funct3 111

   logic clk  = 1'b0;
   logic nrst = 1'b0;

   always #5 clk = ~clk;

   carrd_issue_queue_if #(.DEPTH(DEPTH)) bus ();

   carrd_issue_queue #(
      .DEPTH          (DEPTH),
      .TIMEOUT_CYCLES (TIMEOUT)
   ) dut (
      .clk  (clk),
      .nrst (nrst),
      .bus  (bus)
   );

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        v;
      logic [31:0] instr;
      logic [31:0] xreg;
      logic [2:0]  done;      // {vsldu, vred, vlanes}
      logic        fl;
      logic        expValid;
      logic [31:0] expInstr;
      logic [31:0] expXreg;
      int          expCount;
      logic        expBusy;
      logic        expReady;
   } vec_t;

   vec_t vecs[$];

   typedef struct {
      logic [31:0] instr;
      logic [31:0] xreg;
   } ent_t;

   function automatic vec_t mk(input logic v, input logic [31:0] instr, input logic [31:0] xreg,
                               input logic [2:0] done, input logic fl,
                               input logic eV, input logic [31:0] eI, input logic [31:0] eX,
                               input int eC, input logic eB, input logic eR);
      vec_t t;
      t.v = v; t.instr = instr; t.xreg = xreg; t.done = done; t.fl = fl;
      t.expValid = eV; t.expInstr = eI; t.expXreg = eX;
      t.expCount = eC; t.expBusy = eB; t.expReady = eR;
      return t;
   endfunction

   // Spec rule for instructions that complete without a done pulse.
   function automatic bit refIsConfig(input logic [31:0] instr);
      return (instr[6:0] == 7'h57) && (instr[14:12] == 3'd7);
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic expectAll(input string tag, input logic eV, input logic [31:0] eI,
                            input logic [31:0] eX, input int eC, input logic eB, input logic eR);
      checkOutput({tag, ".op_valid"},   32'(bus.op_valid),   32'(eV));
      checkOutput({tag, ".op_instr"},   bus.op_instr,        eI);
      checkOutput({tag, ".op_xreg"},    bus.op_xreg,         eX);
      checkOutput({tag, ".q_count"},    32'(bus.q_count),    32'(eC));
      checkOutput({tag, ".busy"},       32'(bus.busy),       32'(eB));
      checkOutput({tag, ".base_ready"}, 32'(bus.base_ready), 32'(eR));
   endtask

   // Drive one cycle of inputs, let the rising edge pass, then sample.
   task automatic applyStimulus(input logic v, input logic [31:0] instr, input logic [31:0] xreg,
                                input logic [2:0] done, input logic fl);
      bus.base_valid  = v;
      bus.base_instr  = instr;
      bus.base_xreg   = xreg;
      bus.done_vlanes = done[0];
      bus.done_vred   = done[1];
      bus.done_vsldu  = done[2];
      bus.flush       = fl;
      @(posedge clk);
      #1;
   endtask

   task automatic resetDut();
      bus.base_valid = 1'b0; bus.base_instr = '0; bus.base_xreg = '0;
      bus.done_vlanes = 1'b0; bus.done_vred = 1'b0; bus.done_vsldu = 1'b0;
      bus.flush = 1'b0;
      nrst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      expectAll("reset", 1'b0, 32'h0, 32'h0, 0, 1'b0, 1'b1);
      checkOutput("reset.err_timeout", 32'(bus.err_timeout), 32'h0);
      nrst = 1'b1;
   endtask

   // Reference model state
   ent_t        mq[$];
   bit          mOut;
   bit          mCfg;
   int          mAge;
   logic        mValid;
   logic [31:0] mInstr;
   logic [31:0] mXreg;
   logic        mErr;

   initial begin
      int k;
      bit seen;

      // ---------------- directed table ----------------
      // vadd issue / wait / done_vlanes; done while idle is ignored
      vecs.push_back(mk(1, VADD, 32'hAAAA0001, 3'b000, 0,  0, 32'h0, 32'h0,        1, 1, 1));
      vecs.push_back(mk(0, 0,    0,            3'b000, 0,  1, VADD,  32'hAAAA0001, 0, 1, 1));
      vecs.push_back(mk(0, 0,    0,            3'b000, 0,  0, VADD,  32'hAAAA0001, 0, 1, 1));
      vecs.push_back(mk(0, 0,    0,            3'b000, 0,  0, VADD,  32'hAAAA0001, 0, 1, 1));
      vecs.push_back(mk(0, 0,    0,            3'b001, 0,  0, VADD,  32'hAAAA0001, 0, 0, 1));
      vecs.push_back(mk(0, 0,    0,            3'b111, 0,  0, VADD,  32'hAAAA0001, 0, 0, 1));
      // three vsetvli back to back: issues every second cycle
      vecs.push_back(mk(1, VSET, 1, 3'b000, 0,  0, VADD, 32'hAAAA0001, 1, 1, 1));
      vecs.push_back(mk(1, VSET, 2, 3'b000, 0,  1, VSET, 1,            1, 1, 1));
      vecs.push_back(mk(1, VSET, 3, 3'b000, 0,  0, VSET, 1,            2, 1, 1));
      vecs.push_back(mk(0, 0,    0, 3'b000, 0,  1, VSET, 2,            1, 1, 1));
      vecs.push_back(mk(0, 0,    0, 3'b000, 0,  0, VSET, 2,            1, 1, 1));
      vecs.push_back(mk(0, 0,    0, 3'b000, 0,  1, VSET, 3,            0, 1, 1));
      vecs.push_back(mk(0, 0,    0, 3'b000, 0,  0, VSET, 3,            0, 0, 1));
      // fill to DEPTH with no done; 6th offer refused until done_vred
      vecs.push_back(mk(1, VADD, 11, 3'b000, 0,  0, VSET, 3,  1, 1, 1));
      vecs.push_back(mk(1, VADD, 12, 3'b000, 0,  1, VADD, 11, 1, 1, 1));
      vecs.push_back(mk(1, VADD, 13, 3'b000, 0,  0, VADD, 11, 2, 1, 1));
      vecs.push_back(mk(1, VADD, 14, 3'b000, 0,  0, VADD, 11, 3, 1, 1));
      vecs.push_back(mk(1, VADD, 15, 3'b000, 0,  0, VADD, 11, 4, 1, 0));
      vecs.push_back(mk(1, VADD, 16, 3'b000, 0,  0, VADD, 11, 4, 1, 0));
      vecs.push_back(mk(1, VADD, 16, 3'b000, 0,  0, VADD, 11, 4, 1, 0));
      vecs.push_back(mk(1, VADD, 16, 3'b010, 0,  0, VADD, 11, 4, 1, 0));
      // full queue: pop and offered push in one cycle -> push refused, 4 -> 3
      vecs.push_back(mk(1, VADD, 16, 3'b000, 0,  1, VADD, 12, 3, 1, 1));
      vecs.push_back(mk(1, VADD, 16, 3'b000, 0,  0, VADD, 12, 4, 1, 0));
      vecs.push_back(mk(0, 0,    0,  3'b000, 0,  0, VADD, 12, 4, 1, 0));
      // flush in WAIT with a queued push: everything dropped, later done ignored
      vecs.push_back(mk(1, VADD, 99, 3'b000, 1,  0, VADD, 12, 0, 0, 1));
      vecs.push_back(mk(0, 0,    0,  3'b100, 0,  0, VADD, 12, 0, 0, 1));
      vecs.push_back(mk(0, 0,    0,  3'b000, 0,  0, VADD, 12, 0, 0, 1));

      resetDut();
      foreach (vecs[i]) begin
         applyStimulus(vecs[i].v, vecs[i].instr, vecs[i].xreg, vecs[i].done, vecs[i].fl);
         expectAll($sformatf("vec%0d", i), vecs[i].expValid, vecs[i].expInstr, vecs[i].expXreg,
                   vecs[i].expCount, vecs[i].expBusy, vecs[i].expReady);
         checkOutput($sformatf("vec%0d.err_timeout", i), 32'(bus.err_timeout), 32'h0);
      end

      // ---------------- asynchronous reset mid-operation ----------------
      applyStimulus(1, VADD, 77, 3'b000, 0);
      applyStimulus(1, VADD, 78, 3'b000, 0);
      expectAll("preAsync", 1'b1, VADD, 32'd77, 1, 1'b1, 1'b1);
      bus.base_valid = 1'b0;
      #2;
      nrst = 1'b0;
      #1;
      expectAll("async", 1'b0, 32'h0, 32'h0, 0, 1'b0, 1'b1);
      @(posedge clk);
      #1;
      nrst = 1'b1;

`ifdef CARRD_ISSUE_TIMEOUT_EN
      // ---------------- watchdog ----------------
      resetDut();
      applyStimulus(1, VADD, 1, 3'b000, 0);
      applyStimulus(1, VADD, 2, 3'b000, 0);
      k = 0;
      seen = 0;
      while (!seen && k < 30) begin
         applyStimulus(0, 0, 0, 3'b000, 0);
         k++;
         if (bus.op_valid) seen = 1;
      end
      checkOutput("wd.edgesToReissue", 32'(k), 32'd12);
      checkOutput("wd.reissueXreg", bus.op_xreg, 32'd2);
      checkOutput("wd.err", 32'(bus.err_timeout), 32'h1);
      applyStimulus(0, 0, 0, 3'b000, 1);
      checkOutput("wd.errAfterFlush", 32'(bus.err_timeout), 32'h1);
`else
      k = 0;
      seen = 0;
`endif

      // ---------------- randomized vs reference model ----------------
      resetDut();
      mq.delete();
      mOut = 0; mCfg = 0; mAge = 0;
      mValid = 0; mInstr = '0; mXreg = '0; mErr = 0;
      for (int c = 0; c < 3000; c++) begin
         logic        v;
         logic        fl;
         logic [2:0]  dn;
         logic [31:0] r;
         logic [31:0] ins;
         logic [31:0] xr;
         bit          pushOk;
         ent_t        e;
         v  = ($urandom_range(0, 9) < 6);
         fl = ($urandom_range(0, 99) == 0);
         dn = {($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0)};
         r  = $urandom;
         xr = $urandom;
         if ($urandom_range(0, 2) == 0) ins = {r[31:15], 3'b111, r[11:7], 7'b1010111};
         else                            ins = r;

         applyStimulus(v, ins, xr, dn, fl);

         if (fl) begin
            mq.delete();
            mOut   = 0;
            mValid = 0;
         end else begin
            pushOk = v && (mq.size() < DEPTH);
            mValid = 0;
            if (!mOut && mq.size() > 0) begin
               e      = mq.pop_front();
               mValid = 1;
               mInstr = e.instr;
               mXreg  = e.xreg;
               mOut   = 1;
               mCfg   = refIsConfig(e.instr);
               mAge   = 0;
            end else if (mOut) begin
               mAge++;
               if (mCfg || (dn != 3'b000)) mOut = 0;
`ifdef CARRD_ISSUE_TIMEOUT_EN
               else if (mAge == TIMEOUT + 1) begin
                  mOut = 0;
                  mErr = 1;
               end
`endif
            end
            if (pushOk) begin
               e.instr = ins;
               e.xreg  = xr;
               mq.push_back(e);
            end
         end

         expectAll($sformatf("rnd%0d", c), mValid, mInstr, mXreg, mq.size(),
                   mOut || (mq.size() > 0), mq.size() < DEPTH);
         checkOutput($sformatf("rnd%0d.err_timeout", c), 32'(bus.err_timeout), 32'(mErr));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/carrd_issue_queue.md
# carrd_issue_queue

Upstream issue stage for the CARRD vector coprocessor. Buffers vector instructions and their scalar operand from the base processor in a small FIFO. Presents them one at a time to the integrated coprocessor. Holds each non-configuration instruction until the coprocessor's execution units report completion, so the base processor can run ahead by up to DEPTH instructions.

## Interface
- DEPTH, 4: FIFO entries; power of two, 2..16
- TIMEOUT_CYCLES, 255: watchdog limit in WAIT; used only with CARRD_ISSUE_TIMEOUT_EN

- clk  in  1  clock, all state on rising edge
- nrst  in  1  reset; asynchronous and active-low
- base_valid  in  1  base processor offers an instruction
- base_instr  in  32  vector instruction word
- base_xreg  in  32  scalar rs1 value captured with the instruction
- base_ready  out  1  queue can accept; equals !full
- flush  in  1  synchronous clear of queue and in-flight op
- op_valid  out  1  one-cycle issue pulse to coprocessor
- op_instr  out  32  issued instruction; held stable until the next issue
- op_xreg  out  32  issued scalar operand; held stable until the next issue
- done_vlanes, done_vred, done_vsldu  in  1 each  unit completion pulses
- busy  out  1  FSM not in IDLE or queue non-empty
- q_count  out  $clog2(DEPTH)+1  current occupancy
- err_timeout  out  1  sticky watchdog flag; constant 0 without the macro

## Operation
- Push: base_valid && base_ready stores {base_instr, base_xreg} at the write pointer.
- Pointers are $clog2(DEPTH)+1 bits and wrap naturally. full and empty come from MSB/index compare.
- No pass-through when full: a push is refused while full even if a pop occurs in the same cycle.
- Push and pop in the same cycle when not full: the count is unchanged.
- vconfig: opcode 7'b1010111 and funct3 3'b111. It completes without waiting for a done signal.
- done_any = done_vlanes | done_vred | done_vsldu.
- FSM states:
  - IDLE: if !empty, pop the head into op_instr/op_xreg, set op_valid<=1, go to ISSUE.
  - ISSUE: op_valid<=0. If vconfig, go to IDLE. Else if done_any, go to IDLE. Else go to WAIT.
  - WAIT: on done_any, go to IDLE.
- done_any in IDLE is ignored.
- flush overrides all other inputs:
  - clears both pointers and the count
  - op_valid<=0; state<=IDLE
  - a push in the same cycle is dropped
  - err_timeout is not cleared
- Reset values: pointers 0, q_count 0, state IDLE, op_valid 0, op_instr 0, op_xreg 0, err_timeout 0. busy is 0 and base_ready is 1 during and after reset.

## Timing
- Push at edge N into an empty, idle queue produces op_valid high in cycle N+2.
- op_valid is high for exactly one cycle per instruction.
- vconfig throughput: one issue every 2 cycles.
- Non-config instruction: next issue at the earliest 2 cycles after the done_any edge.
- base_ready is combinational from the count only. It does not depend on base_valid.
- Reset asserted mid-operation drops every entry and in-flight op immediately (asynchronous).

## Configuration
- CARRD_ISSUE_TIMEOUT_EN defined:
  - an 8..16-bit counter clears on entering WAIT and increments each WAIT cycle
  - when it reaches TIMEOUT_CYCLES: err_timeout<=1 (sticky until nrst), state<=IDLE, the op is abandoned
- Undefined: no counter; err_timeout is tied 0; WAIT waits indefinitely.

## Structure
- v_pkg gains:
  - the state enum (S_IDLE, S_ISSUE, S_WAIT)
  - OPC_VECTOR = 7'b1010111
  - FUNCT3_OPCFG = 3'b111
  - an issue-entry struct {instr, xreg}
- One sub-module, carrd_instr_fifo: parameterised by DEPTH and entry width. It provides push, pop, flush, full, empty and count. The top level holds the FSM, output registers and watchdog.

## Test plan
- Reset, then push one vadd (non-config) -> op_valid pulses in cycle N+2 with the matching instr/xreg; busy stays 1 until done_vlanes, then a new issue is possible 2 cycles later.
- Push 4 instructions back-to-back with DEPTH=4 and no done -> q_count reaches 3 after the first pop; a 5th push fills the queue and base_ready=0; a 6th offer is refused until done_vred.
- Push 3 vsetvli in a row -> op_valid at cycles N+2, N+4, N+6; no done inputs required.
- Queue full with a pop and push in the same cycle -> the push is refused and q_count goes 4 -> 3.
- flush during WAIT with 2 queued entries -> next cycle: q_count 0, state IDLE, no op_valid; a later done_vsldu is ignored.
- With CARRD_ISSUE_TIMEOUT_EN and TIMEOUT_CYCLES=10, issue a non-config instruction and withhold done -> err_timeout=1 after 10 WAIT cycles, the next queued entry issues, and err_timeout stays 1 until nrst.
